// File: rtl/multicore_pkg.sv
// Shared widths and enums for the multicore pipeline.
// Includes the memory-access stage types.
package multicore_pkg;

  localparam int unsigned DATA_SIZE  = 32;
  localparam int unsigned INST_SIZE  = 32;
  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned REG_ADDR_W = $clog2(NUM_REGS);
  localparam int unsigned DMEM_BE_W  = DATA_SIZE / 8;

  typedef enum logic [2:0] {
    MEM_B  = 3'b000,
    MEM_H  = 3'b001,
    MEM_W  = 3'b010,
    MEM_BU = 3'b100,
    MEM_HU = 3'b101
  } mem_size_e;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } memaccess_state_e;

endpackage

// File: rtl/memaccess_if.sv
// Data-memory req/ack bus between the memory-access stage and data memory.
interface memaccess_if;
  import multicore_pkg::*;

  logic                 req;
  logic                 we;
  logic [DATA_SIZE-1:0] addr;
  logic [DATA_SIZE-1:0] wdata;
  logic [DMEM_BE_W-1:0] be;
  logic                 ack;
  logic [DATA_SIZE-1:0] rdata;

  modport master (output req, we, addr, wdata, be, input ack, rdata);
  modport slave  (input req, we, addr, wdata, be, output ack, rdata);

endinterface

// File: rtl/mem_load_align.sv
// Selects the addressed byte/half lane of a read word and sign/zero-extends it.
module mem_load_align
  import multicore_pkg::*;
(
  input  logic [DATA_SIZE-1:0] rdata,
  input  logic [1:0]           addr_lo,
  input  logic [2:0]           funct3,
  output logic [DATA_SIZE-1:0] data_c
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = rdata[7:0];
    case (addr_lo)
      2'd1:    byte_v = rdata[15:8];
      2'd2:    byte_v = rdata[23:16];
      2'd3:    byte_v = rdata[31:24];
      default: byte_v = rdata[7:0];
    endcase
    half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    data_c = rdata;
    case (funct3)
      MEM_B:   data_c = {{(DATA_SIZE-8){byte_v[7]}}, byte_v};
      MEM_H:   data_c = {{(DATA_SIZE-16){half_v[15]}}, half_v};
      MEM_BU:  data_c = {{(DATA_SIZE-8){1'b0}}, byte_v};
      MEM_HU:  data_c = {{(DATA_SIZE-16){1'b0}}, half_v};
      default: data_c = rdata;
    endcase
  end

endmodule

// File: rtl/memaccess.sv
// Memory-access pipeline stage: registers execute results, issues one load/store
// over the req/ack bus and stalls the pipeline until it is acknowledged.
module memaccess
  import multicore_pkg::*;
(
  input  logic                  i_aclk,
  input  logic                  i_areset,
  input  logic                  i_en,
  output logic                  o_stall,
  input  logic [REG_ADDR_W-1:0] i_rdest,
  input  logic                  i_cu_regwrite,
  input  logic [1:0]            i_cu_memtoreg,
  input  logic                  i_cu_memread,
  input  logic                  i_cu_memwrite,
  input  logic [2:0]            i_funct3,
  input  logic [INST_SIZE-1:0]  i_pcplus4,
  input  logic [DATA_SIZE-1:0]  i_exe_data,
  input  logic [DATA_SIZE-1:0]  i_store_data,
  output logic [REG_ADDR_W-1:0] o_rdest,
  output logic                  o_cu_regwrite,
  output logic [1:0]            o_cu_memtoreg,
  output logic [INST_SIZE-1:0]  o_pcplus4,
  output logic [DATA_SIZE-1:0]  o_exe_data,
  output logic [DATA_SIZE-1:0]  o_mem_data,
  output logic                  o_mem_fault,
  memaccess_if.master           dmem
);

  memaccess_state_e     state_q;
  logic                 req_q;
  logic                 we_q;
  logic [2:0]           funct3_q;
  logic [DMEM_BE_W-1:0] be_q;
  logic [DATA_SIZE-1:0] wdata_q;

  logic                 capture_c;
  logic                 memop_c;
  logic                 fault_c;
  logic [DMEM_BE_W-1:0] be_c;
  logic [DATA_SIZE-1:0] wdata_c;
  logic [DATA_SIZE-1:0] load_c;

  assign capture_c = i_en & ~o_stall;
  assign memop_c   = i_cu_memread | i_cu_memwrite;

  // Misalignment and illegal-size detection on the incoming instruction.
  always_comb begin
    fault_c = 1'b0;
    if (i_cu_memread) begin
      case (i_funct3)
        3'b011, 3'b110, 3'b111: fault_c = 1'b1;
        3'b001, 3'b101:         if (i_exe_data[0]) fault_c = 1'b1;
        3'b010:                 if (|i_exe_data[1:0]) fault_c = 1'b1;
        default:                ;
      endcase
    end
    if (i_cu_memwrite) begin
      case (i_funct3)
        3'b000:  ;
        3'b001:  if (i_exe_data[0]) fault_c = 1'b1;
        3'b010:  if (|i_exe_data[1:0]) fault_c = 1'b1;
        default: fault_c = 1'b1;
      endcase
    end
  end

  // Store lane replication and byte enables; reads enable the whole word.
  always_comb begin
    be_c    = '1;
    wdata_c = i_store_data;
    if (i_cu_memwrite) begin
      case (i_funct3[1:0])
        2'b00: begin
          be_c    = DMEM_BE_W'(1) << i_exe_data[1:0];
          wdata_c = {4{i_store_data[7:0]}};
        end
        2'b01: begin
          be_c    = i_exe_data[1] ? 4'b1100 : 4'b0011;
          wdata_c = {2{i_store_data[15:0]}};
        end
        default: ;
      endcase
    end
  end

  mem_load_align u_load_align (
    .rdata   (dmem.rdata),
    .addr_lo (o_exe_data[1:0]),
    .funct3  (funct3_q),
    .data_c  (load_c)
  );

  // Stage control: capture, fault reporting and the IDLE/ACCESS handshake.
  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) begin
      state_q       <= IDLE;
      req_q         <= 1'b0;
      o_stall       <= 1'b0;
      o_cu_regwrite <= 1'b0;
      o_mem_fault   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (capture_c) begin
            o_mem_fault   <= memop_c & fault_c;
            o_cu_regwrite <= i_cu_regwrite & ~(memop_c & fault_c);
            if (memop_c && !fault_c) begin
              state_q <= ACCESS;
              req_q   <= 1'b1;
              o_stall <= 1'b1;
            end
          end
        end
        ACCESS: begin
          if (dmem.ack) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            o_stall <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Datapath registers carry no reset; they are qualified by capture/ack.
  always_ff @(posedge i_aclk) begin
    if (capture_c) begin
      o_rdest       <= i_rdest;
      o_cu_memtoreg <= i_cu_memtoreg;
      o_pcplus4     <= i_pcplus4;
      o_exe_data    <= i_exe_data;
      funct3_q      <= i_funct3;
      we_q          <= i_cu_memwrite;
      be_q          <= be_c;
      wdata_q       <= wdata_c;
    end
    if (state_q == ACCESS && dmem.ack && !we_q) begin
      o_mem_data <= load_c;
    end
  end

  assign dmem.req   = req_q;
  assign dmem.we    = we_q;
  assign dmem.addr  = {o_exe_data[DATA_SIZE-1:2], 2'b00};
  assign dmem.wdata = wdata_q;
  assign dmem.be    = be_q;

endmodule

// File: tb/tb_memaccess.sv
// Directed bench for the memory-access stage: one task per scenario.
module tb_memaccess;
  import multicore_pkg::*;

  logic                  i_aclk;
  logic                  i_areset;
  logic                  i_en;
  logic                  o_stall;
  logic [REG_ADDR_W-1:0] i_rdest;
  logic                  i_cu_regwrite;
  logic [1:0]            i_cu_memtoreg;
  logic                  i_cu_memread;
  logic                  i_cu_memwrite;
  logic [2:0]            i_funct3;
  logic [INST_SIZE-1:0]  i_pcplus4;
  logic [DATA_SIZE-1:0]  i_exe_data;
  logic [DATA_SIZE-1:0]  i_store_data;
  logic [REG_ADDR_W-1:0] o_rdest;
  logic                  o_cu_regwrite;
  logic [1:0]            o_cu_memtoreg;
  logic [INST_SIZE-1:0]  o_pcplus4;
  logic [DATA_SIZE-1:0]  o_exe_data;
  logic [DATA_SIZE-1:0]  o_mem_data;
  logic                  o_mem_fault;

  int checks = 0;
  int errors = 0;

  memaccess_if dmem ();

  memaccess dut (
    .i_aclk        (i_aclk),
    .i_areset      (i_areset),
    .i_en          (i_en),
    .o_stall       (o_stall),
    .i_rdest       (i_rdest),
    .i_cu_regwrite (i_cu_regwrite),
    .i_cu_memtoreg (i_cu_memtoreg),
    .i_cu_memread  (i_cu_memread),
    .i_cu_memwrite (i_cu_memwrite),
    .i_funct3      (i_funct3),
    .i_pcplus4     (i_pcplus4),
    .i_exe_data    (i_exe_data),
    .i_store_data  (i_store_data),
    .o_rdest       (o_rdest),
    .o_cu_regwrite (o_cu_regwrite),
    .o_cu_memtoreg (o_cu_memtoreg),
    .o_pcplus4     (o_pcplus4),
    .o_exe_data    (o_exe_data),
    .o_mem_data    (o_mem_data),
    .o_mem_fault   (o_mem_fault),
    .dmem          (dmem)
  );

  initial i_aclk = 1'b0;
  always #5 i_aclk = ~i_aclk;

  task automatic step();
    @(posedge i_aclk);
    @(negedge i_aclk);
  endtask

  task automatic drive_idle();
    i_en          = 1'b0;
    i_rdest       = '0;
    i_cu_regwrite = 1'b0;
    i_cu_memtoreg = 2'b00;
    i_cu_memread  = 1'b0;
    i_cu_memwrite = 1'b0;
    i_funct3      = 3'b000;
    i_pcplus4     = '0;
    i_exe_data    = '0;
    i_store_data  = '0;
    dmem.ack      = 1'b0;
    dmem.rdata    = '0;
  endtask

  task automatic set_op(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] sd,
                        input logic rw, input logic [1:0] mtr);
    i_en          = 1'b1;
    i_cu_memread  = rd;
    i_cu_memwrite = wr;
    i_funct3      = f3;
    i_exe_data    = addr;
    i_store_data  = sd;
    i_cu_regwrite = rw;
    i_cu_memtoreg = mtr;
  endtask

  task automatic test_reset();
    drive_idle();
    i_areset = 1'b1;
    step();
    step();
    checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %0b want 0", o_stall); end
    checks++; if (dmem.req !== 1'b0) begin errors++; $display("FAIL rst_req got %0b want 0", dmem.req); end
    checks++; if (o_cu_regwrite !== 1'b0) begin errors++; $display("FAIL rst_regwrite got %0b want 0", o_cu_regwrite); end
    checks++; if (o_mem_fault !== 1'b0) begin errors++; $display("FAIL rst_fault got %0b want 0", o_mem_fault); end
    i_areset = 1'b0;
    step();
  endtask

  task automatic test_alu();
    set_op(1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'h0, 1'b1, 2'b00);
    i_rdest   = 5'd7;
    i_pcplus4 = 32'h0000_0044;
    step();
    i_en = 1'b0;
    checks++; if (o_exe_data !== 32'h0000_1234) begin errors++; $display("FAIL alu_exe got %h want 00001234", o_exe_data); end
    checks++; if (o_cu_regwrite !== 1'b1) begin errors++; $display("FAIL alu_regwrite got %0b want 1", o_cu_regwrite); end
    checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL alu_stall got %0b want 0", o_stall); end
    checks++; if (dmem.req !== 1'b0) begin errors++; $display("FAIL alu_req got %0b want 0", dmem.req); end
    checks++; if (o_rdest !== 5'd7) begin errors++; $display("FAIL alu_rdest got %0d want 7", o_rdest); end
    checks++; if (o_pcplus4 !== 32'h44) begin errors++; $display("FAIL alu_pc4 got %h want 00000044", o_pcplus4); end
    checks++; if (o_cu_memtoreg !== 2'b00) begin errors++; $display("FAIL alu_mtr got %b want 00", o_cu_memtoreg); end
    step();
    checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL alu_stall2 got %0b want 0", o_stall); end
  endtask

  task automatic test_load_byte(input logic [2:0] f3, input logic [31:0] want, input string nm);
    set_op(1'b1, 1'b0, f3, 32'h0000_0103, 32'h0, 1'b1, 2'b01);
    step();
    i_en = 1'b0;
    checks++; if (o_stall !== 1'b1) begin errors++; $display("FAIL %s_stall1 got %0b want 1", nm, o_stall); end
    checks++; if (dmem.req !== 1'b1) begin errors++; $display("FAIL %s_req got %0b want 1", nm, dmem.req); end
    checks++; if (dmem.addr !== 32'h0000_0100) begin errors++; $display("FAIL %s_addr got %h want 00000100", nm, dmem.addr); end
    checks++; if (dmem.we !== 1'b0 || dmem.be !== 4'b1111) begin errors++; $display("FAIL %s_webe got we=%0b be=%b want we=0 be=1111", nm, dmem.we, dmem.be); end
    dmem.ack   = 1'b1;
    dmem.rdata = 32'h80FF_FF7F;
    step();
    dmem.ack = 1'b0;
    checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL %s_stall_end got %0b want 0", nm, o_stall); end
    checks++; if (dmem.req !== 1'b0) begin errors++; $display("FAIL %s_req_end got %0b want 0", nm, dmem.req); end
    checks++; if (o_mem_data !== want) begin errors++; $display("FAIL %s_data got %h want %h", nm, o_mem_data, want); end
  endtask

  task automatic test_store_half();
    set_op(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'hABCD_5678, 1'b0, 2'b00);
    step();
    i_en = 1'b0;
    checks++; if (dmem.we !== 1'b1 || dmem.be !== 4'b1100) begin errors++; $display("FAIL sh_webe got we=%0b be=%b want we=1 be=1100", dmem.we, dmem.be); end
    checks++; if (dmem.wdata !== 32'h5678_5678) begin errors++; $display("FAIL sh_wdata got %h want 56785678", dmem.wdata); end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (o_stall !== 1'b1 || dmem.req !== 1'b1 || dmem.addr !== 32'h200 || dmem.wdata !== 32'h5678_5678) begin
        errors++;
        $display("FAIL sh_wait%0d got stall=%0b req=%0b addr=%h wdata=%h want 1 1 00000200 56785678",
                 k, o_stall, dmem.req, dmem.addr, dmem.wdata);
      end
    end
    dmem.ack = 1'b1;
    step();
    dmem.ack = 1'b0;
    checks++; if (o_stall !== 1'b0 || dmem.req !== 1'b0) begin errors++; $display("FAIL sh_end got stall=%0b req=%0b want 0 0", o_stall, dmem.req); end
    checks++; if (o_mem_data !== 32'h0000_0080) begin errors++; $display("FAIL sh_memdata_kept got %h want 00000080", o_mem_data); end
  endtask

  task automatic test_fault();
    set_op(1'b1, 1'b0, 3'b010, 32'h0000_0106, 32'h0, 1'b1, 2'b01);
    step();
    i_en = 1'b0;
    checks++; if (o_mem_fault !== 1'b1) begin errors++; $display("FAIL lw_fault got %0b want 1", o_mem_fault); end
    checks++; if (o_cu_regwrite !== 1'b0) begin errors++; $display("FAIL lw_fault_rw got %0b want 0", o_cu_regwrite); end
    checks++; if (dmem.req !== 1'b0 || o_stall !== 1'b0) begin errors++; $display("FAIL lw_fault_bus got req=%0b stall=%0b want 0 0", dmem.req, o_stall); end
    step();
    checks++; if (dmem.req !== 1'b0) begin errors++; $display("FAIL lw_fault_req2 got %0b want 0", dmem.req); end
    set_op(1'b0, 1'b0, 3'b000, 32'h0000_0008, 32'h0, 1'b1, 2'b00);
    step();
    checks++; if (o_mem_fault !== 1'b0 || o_cu_regwrite !== 1'b1) begin errors++; $display("FAIL fault_clear got fault=%0b rw=%0b want 0 1", o_mem_fault, o_cu_regwrite); end
    set_op(1'b0, 1'b1, 3'b011, 32'h0000_0000, 32'h0, 1'b0, 2'b00);
    step();
    i_en = 1'b0;
    checks++; if (o_mem_fault !== 1'b1 || dmem.req !== 1'b0) begin errors++; $display("FAIL st_f3_fault got fault=%0b req=%0b want 1 0", o_mem_fault, dmem.req); end
    set_op(1'b0, 1'b1, 3'b000, 32'h0000_0001, 32'h0000_00A5, 1'b0, 2'b00);
    step();
    i_en = 1'b0;
    checks++; if (o_mem_fault !== 1'b0 || dmem.be !== 4'b0010 || dmem.wdata !== 32'hA5A5_A5A5) begin errors++; $display("FAIL sb_lane got fault=%0b be=%b wdata=%h want 0 0010 a5a5a5a5", o_mem_fault, dmem.be, dmem.wdata); end
    dmem.ack = 1'b1;
    step();
    dmem.ack = 1'b0;
  endtask

  task automatic test_reset_mid();
    set_op(1'b1, 1'b0, 3'b010, 32'h0000_0000, 32'h0, 1'b1, 2'b01);
    step();
    i_en = 1'b0;
    checks++; if (dmem.req !== 1'b1) begin errors++; $display("FAIL rstmid_req_pre got %0b want 1", dmem.req); end
    i_areset = 1'b1;
    #1;
    checks++; if (dmem.req !== 1'b0 || o_stall !== 1'b0 || o_cu_regwrite !== 1'b0) begin errors++; $display("FAIL rstmid_drop got req=%0b stall=%0b rw=%0b want 0 0 0", dmem.req, o_stall, o_cu_regwrite); end
    step();
    i_areset = 1'b0;
    step();
    dmem.ack   = 1'b1;
    dmem.rdata = 32'h1234_5678;
    step();
    dmem.ack = 1'b0;
    checks++; if (dmem.req !== 1'b0 || o_stall !== 1'b0 || o_cu_regwrite !== 1'b0) begin errors++; $display("FAIL rstmid_lateack got req=%0b stall=%0b rw=%0b want 0 0 0", dmem.req, o_stall, o_cu_regwrite); end
  endtask

  task automatic test_back_to_back();
    set_op(1'b1, 1'b0, 3'b010, 32'h0000_0000, 32'h0, 1'b1, 2'b01);
    step();
    set_op(1'b1, 1'b0, 3'b101, 32'h0000_0006, 32'h0, 1'b1, 2'b01);
    checks++; if (o_stall !== 1'b1 || dmem.addr !== 32'h0) begin errors++; $display("FAIL b2b_first got stall=%0b addr=%h want 1 00000000", o_stall, dmem.addr); end
    dmem.ack   = 1'b1;
    dmem.rdata = 32'h0000_0011;
    step();
    dmem.ack = 1'b0;
    checks++; if (o_mem_data !== 32'h11 || o_stall !== 1'b0) begin errors++; $display("FAIL b2b_lw got data=%h stall=%0b want 00000011 0", o_mem_data, o_stall); end
    checks++; if (o_exe_data !== 32'h0) begin errors++; $display("FAIL b2b_nocapture got %h want 00000000", o_exe_data); end
    step();
    i_en = 1'b0;
    checks++; if (o_stall !== 1'b1 || o_exe_data !== 32'h6 || dmem.addr !== 32'h4) begin errors++; $display("FAIL b2b_second got stall=%0b exe=%h addr=%h want 1 00000006 00000004", o_stall, o_exe_data, dmem.addr); end
    dmem.ack   = 1'b1;
    dmem.rdata = 32'hBEEF_0000;
    step();
    dmem.ack = 1'b0;
    checks++; if (o_mem_data !== 32'h0000_BEEF || o_stall !== 1'b0) begin errors++; $display("FAIL b2b_lhu got data=%h stall=%0b want 0000beef 0", o_mem_data, o_stall); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_byte(3'b000, 32'hFFFF_FF80, "lb");
    test_load_byte(3'b100, 32'h0000_0080, "lbu");
    test_store_half();
    test_fault();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
